// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared widths, state encoding and count sizing for seq_divider
package seq_divider_pkg;

  localparam int DIVIDEND_W = 6;
  localparam int DIVISOR_W  = 3;
  localparam int COUNT_W    = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int count_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int DIVISOR_W = seq_divider_pkg::DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   p,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   p_next,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] p_wide;
  logic [DIVISOR_W+1:0] dvs_wide;

  // p stays below divisor between steps, so its top bit is always zero;
  // carrying it through keeps the arithmetic exact without special cases.
  always_comb begin
    p_wide   = {p, bit_in};
    dvs_wide = {2'b00, divisor};
    q_bit    = (p_wide >= dvs_wide);
    p_next   = (DIVISOR_W + 1)'(q_bit ? (p_wide - dvs_wide) : p_wide);
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int DIVIDEND_W = seq_divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = seq_divider_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  import seq_divider_pkg::*;

  localparam int CNT_W = count_width(DIVIDEND_W);

  state_t                state, state_next;
  logic [DIVIDEND_W-1:0] dvd_sh;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    p;
  logic [CNT_W-1:0]      count;
  logic [DIVISOR_W:0]    step_p;
  logic                  step_q;
  logic                  accept;

  assign accept = start && (state != RUN);

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .p       (p),
    .bit_in  (dvd_sh[DIVIDEND_W-1]),
    .divisor (dvs),
    .p_next  (step_p),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (count == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Quotient bits enter the dividend register from the bottom as dividend
  // bits leave the top, so after the last step it holds the quotient.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_sh      <= '0;
      dvs         <= '0;
      p           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor != '0) begin
        dvd_sh      <= dividend;
        dvs         <= divisor;
        p           <= '0;
        count       <= CNT_W'(DIVIDEND_W);
        div_by_zero <= 1'b0;
      end else begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      p      <= step_p;
      dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], step_q};
      count  <= count - CNT_W'(1);
      if (count == CNT_W'(1)) begin
        quotient  <= {dvd_sh[DIVIDEND_W-2:0], step_q};
        remainder <= step_p[DIVISOR_W-1:0];
      end
    end
  end

endmodule
